// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the pipeline NOP word.
package pipe_ctrl_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StRun     = 2'd0,
    StLoadBub = 2'd1,
    StRedirect = 2'd2
  } haz_state_e;

  // sll $0,$0,0 -- the word loaded into IF/ID on a flush
  localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID-stage sources and the EX-stage load destination.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  // $zero is never a real dependency
  always_comb begin
    load_use = ex_mem_read & (ex_rd != '0) &
               ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer: load-use bubbles, branch-redirect flushes, memory-wait freeze.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_stall_req,
  output logic              pc_en,
  output logic              ifreg_en,
  output logic              ifreg_flush,
  output logic              idex_flush,
  output logic              back_en,
  output logic [1:0]        haz_state,
  output logic              mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int unsigned FlW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FlW-1:0] FlushReload = FlW'(FLUSH_CYCLES - 1);
  localparam bit TmoEn = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TmoMatch = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic             load_use;
  haz_state_e       state_q, state_d;
  logic [FlW-1:0]   flush_left_q, flush_left_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pc_en        = 1'b0;
    ifreg_en     = 1'b0;
    ifreg_flush  = 1'b0;
    idex_flush   = 1'b0;
    back_en      = 1'b0;
    if (!rst_n) begin
      // everything stays low while held in reset
    end else if (mem_stall_req) begin
      // whole pipe frozen; state and flush_left hold
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      ifreg_en    = 1'b1;
      ifreg_flush = 1'b1;
      idex_flush  = 1'b1;
      back_en     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d      = StRedirect;
        flush_left_d = FlushReload;
      end else begin
        state_d      = StRun;
        flush_left_d = '0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          back_en = 1'b1;
          if (load_use) begin
            idex_flush = 1'b1;
            state_d    = StLoadBub;
          end else begin
            pc_en    = 1'b1;
            ifreg_en = 1'b1;
          end
        end
        StLoadBub: begin
          pc_en    = 1'b1;
          ifreg_en = 1'b1;
          back_en  = 1'b1;
          state_d  = StRun;
        end
        StRedirect: begin
          pc_en        = 1'b1;
          ifreg_en     = 1'b1;
          ifreg_flush  = 1'b1;
          back_en      = 1'b1;
          flush_left_d = flush_left_q - FlW'(1);
          if (flush_left_q <= FlW'(1)) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_stall_req) begin
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      if (TmoEn && (wait_cnt_q == TmoMatch)) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      flush_left_q  <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign haz_state   = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // pc_en is already forced low in reset, and the flops are held clear there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(!pc_en);
      flush_cnt_q <= flush_cnt_q + CNT_W'(ifreg_flush);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, corner sequences, random vs model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned FC = 3;
  localparam int unsigned MT = 4;
  localparam int unsigned CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_stall_req = 1'b0;
  logic       pc_en, ifreg_en, ifreg_flush, idex_flush, back_en, mem_timeout;
  logic [1:0] haz_state;
  logic [4:0] en_vec;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  assign en_vec = {pc_en, ifreg_en, ifreg_flush, idex_flush, back_en};

  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  pipe_hazard_ctrl #(
    .REG_AW(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_stall_req(mem_stall_req), .pc_en(pc_en),
    .ifreg_en(ifreg_en), .ifreg_flush(ifreg_flush), .idex_flush(idex_flush),
    .back_en(back_en), .haz_state(haz_state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
`else
  pipe_hazard_ctrl #(
    .REG_AW(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_stall_req(mem_stall_req), .pc_en(pc_en),
    .ifreg_en(ifreg_en), .ifreg_flush(ifreg_flush), .idex_flush(idex_flush),
    .back_en(back_en), .haz_state(haz_state), .mem_timeout(mem_timeout)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mrd, input logic [4:0] rd,
                       input logic br, input logic ms);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_mem_read = mrd; ex_rd = rd; ex_branch_taken = br; mem_stall_req = ms;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // expected en_vec = {pc_en, ifreg_en, ifreg_flush, idex_flush, back_en}
  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, mrd;
    logic [4:0] rd;
    logic       br, ms;
    logic [4:0] ex;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic mrd, logic [4:0] rd, logic br, logic ms,
                              logic [4:0] ex, logic [1:0] st);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mrd = mrd;
    v.rd = rd; v.br = br; v.ms = ms; v.ex = ex; v.st = st;
    return v;
  endfunction

  // Reference model: remaining redirect slots, pending-bubble flag, wait length, sticky timeout
  int m_redir, m_wait, m_stalls, m_flushes;
  bit m_bub, m_tmo;

  initial begin
    // -------- reset behaviour: enables stay low even with a branch pending
    drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    #2;
    chk("rst_en", 32'(en_vec), 32'h0);
    chk("rst_state", 32'(haz_state), 32'd0);
    chk("rst_tmo", 32'(mem_timeout), 32'd0);
    do_reset();

    // -------- directed table
    vecs.push_back(mk("lu_stall",   8, 0, 1, 0, 1, 8, 0, 0, 5'b00011, 0));
    vecs.push_back(mk("lu_bub",     8, 0, 1, 0, 1, 8, 0, 0, 5'b11001, 1));
    vecs.push_back(mk("lu_run",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("rd_zero",    0, 0, 1, 0, 1, 0, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("no_use",     8, 0, 0, 0, 1, 8, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("rt_use",     3, 9, 0, 1, 1, 9, 0, 0, 5'b00011, 0));
    vecs.push_back(mk("rt_bub",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 1));
    vecs.push_back(mk("br",         0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 0));
    vecs.push_back(mk("redir1",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("redir2",     0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("redir_done", 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("br_lu",      8, 0, 1, 0, 1, 8, 1, 0, 5'b11111, 0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk("ms_redir", 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 2));
    end
    vecs.push_back(mk("resume1",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("resume2",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("resume_run", 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("br_a",       0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 0));
    vecs.push_back(mk("redir_a",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("br_reload",  0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 2));
    vecs.push_back(mk("reload1",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("reload2",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11101, 2));
    vecs.push_back(mk("reload_run", 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0));
    vecs.push_back(mk("lu_b",       8, 0, 1, 0, 1, 8, 0, 0, 5'b00011, 0));
    vecs.push_back(mk("ms_bub",     8, 0, 1, 0, 1, 8, 0, 1, 5'b00000, 1));
    vecs.push_back(mk("bub_mask",   8, 0, 1, 0, 1, 8, 0, 0, 5'b11001, 1));
    vecs.push_back(mk("bub_run",    0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mrd, vecs[i].rd,
            vecs[i].br, vecs[i].ms);
      #1;
      chk({vecs[i].name, "_en"}, 32'(en_vec), 32'(vecs[i].ex));
      chk({vecs[i].name, "_st"}, 32'(haz_state), 32'(vecs[i].st));
    end

    // -------- timeout sets after the MT-th stalled edge and is sticky
    do_reset();
    for (int i = 0; i < int'(MT); i++) begin
      @(negedge clk);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      #1;
      chk("tmo_pre", 32'(mem_timeout), 32'd0);
    end
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("tmo_set", 32'(mem_timeout), 32'd1);
    @(negedge clk);
    #1;
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);

    // -------- asynchronous reset in the middle of a stall inside a redirect
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("ar_pre_state", 32'(haz_state), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(haz_state), 32'd0);
    chk("ar_tmo", 32'(mem_timeout), 32'd0);
    chk("ar_en", 32'(en_vec), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // -------- randomized run against the model
    do_reset();
    m_redir = 0; m_bub = 1'b0; m_wait = 0; m_tmo = 1'b0; m_stalls = 0; m_flushes = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] rs, rt, rd, ex;
      logic urs, urt, mrd, br, ms, lu;
      int st;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      urs = 1'($urandom_range(0, 1));
      urt = 1'($urandom_range(0, 1));
      mrd = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 9) == 0);
      ms  = ($urandom_range(0, 6) == 0);
      @(negedge clk);
      drive(rs, rt, urs, urt, mrd, rd, br, ms);

      lu = mrd && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
      st = (m_redir > 0) ? 2 : (m_bub ? 1 : 0);
      if (ms) begin
        ex = 5'b00000;
      end else if (br) begin
        ex = 5'b11111;
        m_redir = int'(FC) - 1;
        m_bub = 1'b0;
      end else if (m_redir > 0) begin
        ex = 5'b11101;
        m_redir--;
      end else if (m_bub) begin
        ex = 5'b11001;
        m_bub = 1'b0;
      end else if (lu) begin
        ex = 5'b00011;
        m_bub = 1'b1;
      end else begin
        ex = 5'b11001;
      end

      #1;
      chk("rnd_en", 32'(en_vec), 32'(ex));
      chk("rnd_st", 32'(haz_state), 32'(st));
      chk("rnd_tmo", 32'(mem_timeout), 32'(m_tmo));
`ifdef HAZ_PERF_CNT_EN
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stalls % (1 << CW)));
      chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_flushes % (1 << CW)));
`endif
      // state advanced by the coming posedge
      if (ms) begin
        if (m_wait == int'(MT) - 1) m_tmo = 1'b1;
        m_wait = (m_wait < (1 << CW) - 1) ? m_wait + 1 : m_wait;
      end else begin
        m_wait = 0;
      end
      if (ex[4] == 1'b0) m_stalls++;
      if (ex[2] == 1'b1) m_flushes++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
